// File: rtl/testchain_pkg.sv
// Shared constants and types for the testchain BIST driver/checker.
package testchain_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;
    localparam logic [LFSR_W-1:0] SEED_DEF = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/prbs16.sv
// 16-bit Fibonacci PRBS generator (x^16+x^14+x^13+x^11+1) with seed load and advance enable.
module prbs16
    import testchain_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic              prbs_bit
);

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= RST_VAL;
        end else if (load) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAP_MASK)};
        end
    end

    assign prbs_bit = lfsr[LFSR_W-1];

endmodule

// File: rtl/testchain_bist.sv
// Drives a PRBS stream into the flop chain and checks the returned stream N cycles later.
module testchain_bist
    import testchain_pkg::*;
#(
    parameter int unsigned       N        = 2,
    parameter int unsigned       LEN_W    = 16,
    parameter int unsigned       CNT_W    = 16,
    parameter logic [LFSR_W-1:0] SEED_DEF = testchain_pkg::SEED_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [LFSR_W-1:0] seed,
    output logic              chain_din,
    input  logic              chain_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [LEN_W-1:0]  first_err_idx
);

    localparam int unsigned CYC_W = LEN_W + 1;
    localparam logic [CYC_W-1:0] N_C = CYC_W'(N);

    state_t            state, state_n;
    logic [CYC_W-1:0]  cyc, cyc_n;
    logic [LEN_W-1:0]  len_q, len_n;
    logic              chain_din_n, busy_n, done_n, pass_n;
    logic [CNT_W-1:0]  err_n;
    logic [LEN_W-1:0]  first_n;
    logic [LFSR_W-1:0] seed_eff;
    logic              load, tx_adv, rx_adv, tx_bit, rx_bit;

    assign seed_eff = (seed == '0) ? SEED_DEF : seed;

    prbs16 #(.RST_VAL(SEED_DEF)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .seed     (seed_eff),
        .advance  (tx_adv),
        .prbs_bit (tx_bit)
    );

    prbs16 #(.RST_VAL(SEED_DEF)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .seed     (seed_eff),
        .advance  (rx_adv),
        .prbs_bit (rx_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cyc           <= '0;
            len_q         <= '0;
            chain_din     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '1;
        end else begin
            state         <= state_n;
            cyc           <= cyc_n;
            len_q         <= len_n;
            chain_din     <= chain_din_n;
            busy          <= busy_n;
            done          <= done_n;
            pass          <= pass_n;
            err_count     <= err_n;
            first_err_idx <= first_n;
        end
    end

    // chain_din is registered, so the bit for RUN cycle c is chosen one cycle earlier
    always_comb begin
        state_n     = state;
        cyc_n       = cyc;
        len_n       = len_q;
        chain_din_n = 1'b0;
        err_n       = err_count;
        first_n     = first_err_idx;
        pass_n      = pass;
        load        = 1'b0;
        tx_adv      = 1'b0;
        rx_adv      = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    len_n   = len;
                    err_n   = '0;
                    first_n = '1;
                    pass_n  = 1'b0;
                    load    = 1'b1;
                    cyc_n   = '0;
                    state_n = FLUSH;
                end
            end
            FLUSH: begin
                if (cyc == N_C - CYC_W'(1)) begin
                    cyc_n = '0;
                    if (len_q != '0) begin
                        state_n     = RUN;
                        chain_din_n = tx_bit;
                        tx_adv      = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            RUN: begin
                if (cyc + CYC_W'(1) < CYC_W'(len_q)) begin
                    chain_din_n = tx_bit;
                    tx_adv      = 1'b1;
                end
                if (cyc >= N_C) begin
                    rx_adv = 1'b1;
                    if (chain_dout != rx_bit) begin
                        if (err_count != '1) begin
                            err_n = err_count + CNT_W'(1);
                        end
                        if (err_count == '0) begin
                            first_n = LEN_W'(cyc - N_C);
                        end
                    end
                end
                if (cyc == CYC_W'(len_q) + N_C - CYC_W'(1)) begin
                    state_n = DONE;
                end else begin
                    cyc_n = cyc + CYC_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
        if (state_n == DONE) begin
            pass_n = (err_n == '0);
        end
    end

endmodule

// File: tb/tb_testchain_bist.sv
// Scoreboard bench: PRBS loopback through a modelled flop chain with optional fault injection.
module tb_testchain_bist;

    localparam int unsigned N     = 2;
    localparam int unsigned LEN_W = 16;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int unsigned cyc;
        logic        din;
        logic        busy;
    } din_t;

    typedef struct {
        int unsigned cyc;
        int unsigned err;
        int unsigned first;
        logic        pass;
    } res_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [15:0]      seed = '0;
    logic             chain_din;
    logic             chain_dout;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_count;
    logic [LEN_W-1:0] first_err_idx;

    logic [N-1:0]     chain_q = '0;
    int unsigned      cycle = 0;
    int               mode = 0;
    int unsigned      flip_cyc = 0;
    int unsigned      tests = 0;
    int unsigned      fails = 0;

    din_t din_q[$];
    res_t res_q[$];

    testchain_bist #(.N(N), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .seed          (seed),
        .chain_din     (chain_din),
        .chain_dout    (chain_dout),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_idx (first_err_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle   <= cycle + 1;
        chain_q <= {chain_q[N-2:0], chain_din};
    end

    // mode 1: inverted loopback, mode 2: single flip of the bit sampled at flip_cyc
    assign chain_dout = chain_q[N-1] ^ (mode == 1) ^ (mode == 2 && cycle == flip_cyc);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cycle);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Called just after a rising edge; returns just after the edge following the done cycle.
    task automatic issue_test(input int unsigned ln, input logic [15:0] sd, input int md,
                              input int unsigned k, input bit extra);
        logic        tx[$];
        logic [15:0] l;
        int unsigned cnt, first, c0, dc, j;
        din_t        d;
        res_t        r;
        l = (sd == 16'h0) ? 16'hACE1 : sd;
        for (int i = 0; i < int'(ln); i++) begin
            tx.push_back(l[15]);
            l = lfsr_next(l);
        end
        cnt = 0;
        first = 32'hFFFF;
        for (int i = 0; i < int'(ln); i++) begin
            if ((md == 1) || (md == 2 && i == int'(k))) begin
                if (cnt == 0) first = i;
                cnt++;
            end
        end
        c0 = cycle;
        dc = (ln > 0) ? c0 + 1 + 2 * N + ln : c0 + 1 + N;
        for (int unsigned c = c0 + 1; c <= dc + 1; c++) begin
            d.cyc  = c;
            d.busy = (c <= dc);
            d.din  = 1'b0;
            if (c > c0 + N) begin
                j = c - (c0 + N + 1);
                if (j < ln) d.din = tx[j];
            end
            din_q.push_back(d);
        end
        r.cyc   = dc;
        r.err   = (cnt > CNT_MAX) ? CNT_MAX : cnt;
        r.first = first;
        r.pass  = (cnt == 0);
        res_q.push_back(r);
        mode     = md;
        flip_cyc = c0 + 2 * N + 1 + k;
        len      = LEN_W'(ln);
        seed     = sd;
        start    = 1'b1;
        do begin
            @(posedge clk);
            #1;
            start = extra && (cycle == c0 + N + 3 || cycle == dc);
        end while (cycle != dc + 1);
        start = 1'b0;
    endtask

    din_t e;
    res_t r;

    always @(negedge clk) begin
        if (!rst) begin
            while (din_q.size() > 0 && din_q[0].cyc < cycle) void'(din_q.pop_front());
            if (din_q.size() > 0 && din_q[0].cyc == cycle) begin
                e = din_q.pop_front();
                chk("chain_din", 32'(chain_din), 32'(e.din));
                chk("busy", 32'(busy), 32'(e.busy));
            end
            if (done) begin
                if (res_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d", cycle);
                end else begin
                    r = res_q.pop_front();
                    chk("done_cycle", cycle, r.cyc);
                    chk("err_count", 32'(err_count), r.err);
                    chk("first_err_idx", 32'(first_err_idx), r.first);
                    chk("pass", 32'(pass), 32'(r.pass));
                end
            end else if (res_q.size() > 0 && cycle > res_q[0].cyc) begin
                tests++;
                fails++;
                $display("FAIL done_missing: no done by cycle %0d expected at %0d", cycle, res_q[0].cyc);
                void'(res_q.pop_front());
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_chain_din", 32'(chain_din), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_first_err_idx", 32'(first_err_idx), 32'hFFFF);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned ln, k;
        int          md;
        logic [15:0] sd;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue_test(32, 16'h0000, 0, 0, 0);
        issue_test(32, 16'h1234, 1, 0, 0);
        issue_test(32, 16'h0000, 2, 5, 0);
        issue_test(80, 16'hBEEF, 1, 0, 0);
        issue_test(0, 16'h0000, 0, 0, 0);
        issue_test(1, 16'h8000, 2, 0, 0);
        issue_test(40, 16'h5A5A, 0, 0, 1);

        // abort mid-RUN: outputs return to reset values and no done follows
        len   = 16'd40;
        seed  = 16'hC0DE;
        mode  = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        issue_test(24, 16'h0000, 0, 0, 0);

        for (int t = 0; t < 25; t++) begin
            ln = $urandom_range(0, 70);
            md = (ln == 0) ? 0 : int'($urandom_range(0, 2));
            k  = (ln > 0) ? $urandom_range(0, ln - 1) : 0;
            sd = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            issue_test(ln, sd, md, k, ($urandom_range(0, 3) == 0) && ln > 0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("results_outstanding", 32'(res_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/testchain_bist.md
Name: testchain_bist

Overview:
- Built-in driver/checker for the flip-flop shift chain (testchain). This block is the other end of that chain's serial interface.
- Generates a PRBS bit stream onto the chain input and samples the chain output. It compares the sampled bits against a locally regenerated stream delayed by the chain length.
- Reports error count, first failing bit index and pass/fail.
- Sits next to the chain in the test-structure area. Driven from the design's control/status logic.

Parameters:
- N, 2: chain length in flops. Equals the chain's N and the expected latency in cycles. Must be 1..2^LEN_W-1.
- LEN_W, 16: width of the pattern length and bit-index fields.
- CNT_W, 16: width of the saturating error counter.
- SEED_DEF, 16'hACE1: LFSR seed used when seed input is zero.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a test. Ignored while busy.
- len  in  LEN_W  number of PRBS bits to shift. Sampled with start.
- seed  in  16  LFSR seed. Sampled with start. 0 selects SEED_DEF.
- chain_din  out  1  registered serial bit to chain input
- chain_dout  in  1  serial bit from chain output
- busy  out  1  high from the cycle after start until the done cycle, inclusive
- done  out  1  one-cycle pulse at end of test
- pass  out  1  held result: err_count==0. Valid from done until next start.
- err_count  out  CNT_W  mismatches. Saturates at all-ones.
- first_err_idx  out  LEN_W  index of first mismatching bit. All-ones if none.

Behaviour:
- Reset (async, rst=1), all outputs:
  - chain_din=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones.
  - FSM=IDLE, counters=0, both LFSRs=SEED_DEF.
- Reset mid-test aborts immediately. No done pulse.
- LFSR (Fibonacci, 16 bit, x^16+x^14+x^13+x^11+1):
  - Output bit = lfsr[15].
  - Next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Two instances, both loaded with the same seed at start:
  - TX LFSR advances per transmitted bit.
  - RX (expected) LFSR advances per checked bit.
- FSM states: IDLE, FLUSH, RUN, DONE.
- IDLE:
  - start=1 latches len/seed, clears err_count, sets first_err_idx=all-ones, pass=0.
  - Goes to FLUSH.
- FLUSH:
  - Exactly N cycles, chain_din=0. Clears stale chain content.
  - Then goes to RUN if len>0, else DONE.
- RUN:
  - Cycle counter cyc runs 0..len+N-1 (width LEN_W+1).
  - Transmit: when cyc<len, chain_din carries TX bit cyc and TX LFSR advances. Otherwise chain_din=0.
  - Check: when cyc>=N, chain_dout is compared with RX LFSR bit (cyc-N) and RX LFSR advances. Chain latency is exactly N cycles: bit driven in cycle c is sampled in cycle c+N.
  - On mismatch, err_count increments unless already all-ones.
  - On the first mismatch only, first_err_idx = cyc-N (truncated to LEN_W).
  - After cyc=len+N-1, goes to DONE.
- DONE:
  - One cycle: done=1, busy=1, pass=(err_count==0).
  - Then IDLE with busy=0. Results held.
- Timing: with start sampled in cycle 0, done=1 in cycle 1+2N+len (len>0) or 1+N (len=0).
- start while busy (including DONE cycle) is ignored.
- start in the cycle after DONE is accepted normally.
- first_err_idx all-ones with err_count>0 is legal only if the first error is at index all-ones. Verification disambiguates via err_count.

Decomposition:
- Package testchain_pkg holds:
  - LFSR width (16), LFSR tap mask 16'hB400, SEED_DEF.
  - FSM state enum {IDLE, FLUSH, RUN, DONE}.
- Sub-module prbs16: seed load, advance enable, output bit. Instantiated twice (TX and RX).
- FSM and counters stay in testchain_bist.

Test Plan:
- Loopback through testchain N=2, len=32, seed=0 -> done in cycle 37, err_count=0, pass=1, first_err_idx=16'hFFFF.
- Inverter inserted between chain and chain_dout, N=2, len=32 -> err_count=32, first_err_idx=0, pass=0.
- Flip chain_dout only when cyc-N=5, len=32 -> err_count=1, first_err_idx=5, pass=0.
- CNT_W=4, inverted loopback, len=40 -> err_count=15 (saturated), first_err_idx=0.
- len=0, N=2 -> chain_din=0 for cycles 1..2, done in cycle 3, pass=1, err_count=0.
- Control: second start pulse during RUN -> ignored; a single done with unchanged counts. rst asserted mid-RUN -> all outputs at reset values next cycle, no done pulse. New start afterwards completes normally.
